// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and helpers for the serial-in/parallel-out receiver
// Optional parity stage is enabled by SIPO_PARITY_EN in the importing files.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// rtl/sipo_hold_reg.sv - output holding register with valid/ready handshake and sticky overrun
// SIPO_PARITY_EN adds a parity_err flag that travels with each committed word.
module sipo_hold_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             cp,
    input  logic             mr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`ifdef SIPO_PARITY_EN
    input  logic             load_perr,
    output logic             parity_err,
`endif
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;
`endif

    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef SIPO_PARITY_EN
        perr_d    = perr_q;
`endif
        if (load) begin
            // A word may land in the same cycle the old one is taken.
            if (!valid_q || dout_ready) begin
                dout_d  = load_data;
                valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                perr_d  = load_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge cp) begin
        if (mr) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef SIPO_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out receiver, framed by sync, gated by ce
// Define SIPO_PARITY_EN to sample an even-parity bit after each word and expose parity_err.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             cp,
    input  logic             mr,
    input  logic             ce,
    input  logic             sin,
    input  logic             sync,
    output logic [WIDTH-1:0] shreg,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int            CW       = clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shifted;
    logic             commit;
    logic [WIDTH-1:0] commit_word;
`ifdef SIPO_PARITY_EN
    logic             commit_perr;
`endif

    always_comb begin
        shifted     = MSB_FIRST ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        commit      = 1'b0;
        commit_word = shifted;
`ifdef SIPO_PARITY_EN
        commit_perr = 1'b0;
`endif
        if (ce) begin
            // sync always starts a fresh frame, whatever state we were in.
            if (sync) begin
                shreg_d   = shifted;
                bit_cnt_d = CW'(1);
                state_d   = SHIFT;
            end else begin
                case (state_q)
                    SHIFT: begin
                        shreg_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
`ifdef SIPO_PARITY_EN
                            state_d   = PARITY;
`else
                            state_d   = IDLE;
                            commit    = 1'b1;
`endif
                        end
                    end
                    PARITY: begin
                        state_d = IDLE;
`ifdef SIPO_PARITY_EN
                        commit      = 1'b1;
                        commit_word = shreg_q;
                        commit_perr = (^shreg_q) ^ sin;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge cp) begin
        if (mr) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .cp         (cp),
        .mr         (mr),
        .load       (commit),
        .load_data  (commit_word),
`ifdef SIPO_PARITY_EN
        .load_perr  (commit_perr),
        .parity_err (parity_err),
`endif
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

    assign shreg = shreg_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - randomized bench with a bit-queue reference model, both shift orders
// Covers the SIPO_PARITY_EN build when that macro is defined.
module tb_sipo_deserializer;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic cp = 1'b0;
    logic mr_i = 1'b1, ce_i = 1'b0, sin_i = 1'b0, sync_i = 1'b0, rdy_i = 1'b0;
    logic [W-1:0] shreg_m, dout_m, shreg_l, dout_l;
    logic valid_m, valid_l, over_m, over_l, busy_m, busy_l;
`ifdef SIPO_PARITY_EN
    logic perr_m, perr_l;
`endif

    always #5 cp = ~cp;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_m (
        .cp(cp), .mr(mr_i), .ce(ce_i), .sin(sin_i), .sync(sync_i),
        .shreg(shreg_m), .dout(dout_m), .dout_valid(valid_m), .dout_ready(rdy_i),
        .overrun(over_m),
`ifdef SIPO_PARITY_EN
        .parity_err(perr_m),
`endif
        .busy(busy_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_l (
        .cp(cp), .mr(mr_i), .ce(ce_i), .sin(sin_i), .sync(sync_i),
        .shreg(shreg_l), .dout(dout_l), .dout_valid(valid_l), .dout_ready(rdy_i),
        .overrun(over_l),
`ifdef SIPO_PARITY_EN
        .parity_err(perr_l),
`endif
        .busy(busy_l)
    );

    int n_vec = 0;
    int n_miss = 0;

    // Reference model: the bits of the current frame in arrival order, plus the
    // last W bits ever shifted (oldest first) to predict the live shift register.
    bit m_bits[$];
    bit m_hist[$];
    bit m_in_frame = 0, m_pwait = 0, m_valid = 0, m_over = 0, m_perr = 0;
    logic [W-1:0] m_dout_m = '0, m_dout_l = '0;

    bit rdy_base = 0, rdy_last = 0;
    int gap_at = -1, gap_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] hist_word(input bit msb);
        logic [W-1:0] r;
        int n;
        r = '0;
        n = m_hist.size();
        for (int i = 0; i < n; i++) begin
            if (msb) r[i] = m_hist[n-1-i];
            else     r[W-1-i] = m_hist[n-1-i];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] frame_word(input bit msb);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) r[W-1-i] = m_bits[i];
            else     r[i] = m_bits[i];
        end
        return r;
    endfunction

    task automatic push_hist(input bit b);
        m_hist.push_back(b);
        if (m_hist.size() > W) void'(m_hist.pop_front());
    endtask

    task automatic model_edge();
        bit done, pbit, ones;
        done = 0;
        pbit = 0;
        if (mr_i) begin
            m_bits.delete();
            m_hist.delete();
            m_in_frame = 0; m_pwait = 0; m_valid = 0; m_over = 0; m_perr = 0;
            m_dout_m = '0; m_dout_l = '0;
        end else begin
            if (ce_i) begin
                if (sync_i) begin
                    m_bits.delete();
                    m_bits.push_back(sin_i);
                    push_hist(sin_i);
                    m_in_frame = 1;
                    m_pwait = 0;
                end else if (m_in_frame && !m_pwait) begin
                    m_bits.push_back(sin_i);
                    push_hist(sin_i);
                    if (m_bits.size() == W) begin
                        if (PAR_EN) m_pwait = 1;
                        else begin done = 1; m_in_frame = 0; end
                    end
                end else if (m_pwait) begin
                    pbit = sin_i;
                    done = 1;
                    m_in_frame = 0;
                    m_pwait = 0;
                end
            end
            if (done) begin
                if (!m_valid || rdy_i) begin
                    ones = 0;
                    foreach (m_bits[i]) ones ^= m_bits[i];
                    m_dout_m = frame_word(1);
                    m_dout_l = frame_word(0);
                    m_valid = 1;
                    m_perr = ones ^ pbit;
                end else begin
                    m_over = 1;
                end
            end else if (m_valid && rdy_i) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("shreg_msb", shreg_m, hist_word(1));
        chk("shreg_lsb", shreg_l, hist_word(0));
        chk("dout_msb", dout_m, m_dout_m);
        chk("dout_lsb", dout_l, m_dout_l);
        chk("valid_msb", valid_m, m_valid);
        chk("valid_lsb", valid_l, m_valid);
        chk("overrun_msb", over_m, m_over);
        chk("overrun_lsb", over_l, m_over);
        chk("busy_msb", busy_m, m_in_frame);
        chk("busy_lsb", busy_l, m_in_frame);
`ifdef SIPO_PARITY_EN
        chk("perr_msb", perr_m, m_perr);
        chk("perr_lsb", perr_l, m_perr);
`endif
    endtask

    task automatic tick();
        @(posedge cp);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic cyc(input bit c, input bit s, input bit d);
        ce_i = c; sync_i = s; sin_i = d;
        tick();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit par);
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) for (int g = 0; g < gap_len; g++) cyc(1'b0, 1'b0, 1'($urandom));
            rdy_i = (rdy_last && !PAR_EN && i == W-1) ? 1'b1 : rdy_base;
            cyc(1'b1, i == 0, w[W-1-i]);
        end
        if (PAR_EN) begin
            rdy_i = rdy_last ? 1'b1 : rdy_base;
            cyc(1'b1, 1'b0, par);
        end
        rdy_i = rdy_base;
    endtask

    task automatic drain();
        rdy_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rdy_i = rdy_base;
    endtask

    initial begin
        mr_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("reset_dout", dout_m, 8'h00);
        chk("reset_valid", valid_m, 1'b0);
        mr_i = 1'b0;

        send_word(8'hA5, 1'b0);
        chk("basic_a5_msb", dout_m, 8'hA5);
        chk("basic_a5_lsb", dout_l, 8'hA5);
        chk("basic_valid", valid_m, 1'b1);
        chk("basic_busy", busy_m, 1'b0);

        drain();
        send_word(8'hC0, 1'b0);
        chk("order_msb", dout_m, 8'hC0);
        chk("order_lsb", dout_l, 8'h03);

        drain();
        send_word(8'h3C, 1'b0);
        send_word(8'hC3, 1'b0);
        chk("overrun_keep", dout_m, 8'h3C);
        chk("overrun_flag", over_m, 1'b1);

        rdy_last = 1;
        send_word(8'hC3, 1'b0);
        rdy_last = 0;
        chk("simul_dout", dout_m, 8'hC3);
        chk("simul_valid", valid_m, 1'b1);

        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'($urandom));
        mr_i = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        mr_i = 1'b0;
        chk("mr_dout", dout_m, 8'h00);
        chk("mr_shreg", shreg_m, 8'h00);
        chk("mr_over", over_m, 1'b0);
        chk("mr_busy", busy_m, 1'b0);
        send_word(8'hA5, 1'b0);
        chk("post_mr_dout", dout_m, 8'hA5);

        drain();
        gap_at = 4; gap_len = 3;
        send_word(8'hA5, 1'b0);
        gap_at = -1;
        chk("ce_gap_dout", dout_m, 8'hA5);

        drain();
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
        send_word(8'h5A, 1'b0);
        chk("resync_dout", dout_m, 8'h5A);
        chk("resync_over", over_m, 1'b0);

`ifdef SIPO_PARITY_EN
        drain();
        send_word(8'hA5, 1'b0);
        chk("par0_perr", perr_m, 1'b0);
        drain();
        for (int i = 0; i < W; i++) cyc(1'b1, i == 0, 1'(8'hA5 >> (W-1-i)));
        chk("par_valid_late", valid_m, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("par_valid_now", valid_m, 1'b1);
        chk("par1_perr", perr_m, 1'b1);
`endif

        for (int f = 0; f < 40; f++) begin
            rdy_base = 1'($urandom_range(0, 1));
            rdy_i = rdy_base;
            gap_at = $urandom_range(0, W);
            gap_len = $urandom_range(0, 3);
            send_word(W'($urandom), 1'($urandom));
        end
        gap_at = -1;

        for (int i = 0; i < 600; i++) begin
            mr_i  = ($urandom_range(0, 99) == 0);
            rdy_i = 1'($urandom);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 1'($urandom));
        end
        mr_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out receiver. It is the partner of the team's 8-bit parallel-to-serial shift register: it captures the bit stream that the shift register emits, MSB (p7) first, and reassembles it into words. Completed words are presented on a holding register with a valid/ready handshake, and overrun is detected. It sits at the far end of the serial link, feeding parallel logic.

Parameters:
WIDTH, 8, data bits per word (2..32)
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = it lands in dout[0]

Ports:
cp  input  1  clock; all state changes on rising edge
mr  input  1  reset, synchronous, active-high
ce  input  1  clock enable; when low, sampling and bit counting freeze (handshake still live)
sin  input  1  serial data in
sync  input  1  frame start; high for one enabled cycle together with the first data bit
shreg  output  WIDTH  live shift register contents (debug/monitor)
dout  output  WIDTH  holding register, last completed word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when high with dout_valid
overrun  output  1  sticky; a word completed while the holding register was full
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Clocking and reset: one clock (cp). Reset is synchronous and active-high (mr).
- Reset values: shreg=0, dout=0, dout_valid=0, overrun=0, busy=0, bit_cnt=0, state=IDLE. A reset mid-frame discards the partial word.
- State machine:
  - IDLE -> SHIFT on ce&sync. That cycle samples bit 0 and sets bit_cnt=1.
  - SHIFT: each ce cycle shifts sin in and increments bit_cnt.
  - On the cycle that samples bit WIDTH-1, the word completes and the state goes to IDLE (or PARITY when the optional feature is on).
  - ce low in any state holds state, shreg and bit_cnt.
- Shift direction:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: shreg <= {sin, shreg[WIDTH-1:1]}.
- sync during SHIFT restarts the frame: the partial word is dropped, the sin of that cycle becomes bit 0, and bit_cnt=1. No overrun is flagged.
- Completion: the word written to dout equals the next-value of shreg, including the final bit. So dout and dout_valid update on the same edge that samples the last bit; latency is 0 cycles after the last bit edge.
- Handshake:
  - A transfer occurs when dout_valid&dout_ready.
  - Transfer only (no completion) clears dout_valid next cycle.
  - Completion with dout_valid=0, or with a simultaneous transfer: load dout, dout_valid=1.
  - Completion with dout_valid=1 and dout_ready=0: dout is kept (new word dropped) and overrun is set.
- overrun clears only on mr.
- dout_valid is independent of ce.
- busy = (state != IDLE).
- Back-to-back frames: sync may be asserted on the cycle immediately after completion; no idle gap is required.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - After the WIDTH data bits the FSM enters PARITY and samples one extra ce cycle of sin as an even-parity bit.
  - The word is committed to dout on that parity edge, not on the last data edge; latency is therefore one enabled cycle later.
  - Adds output parity_err (1 bit, reset 0), which is written alongside dout on each commit: parity_err = ^word ^ parity_bit.
  - On an overrun drop, parity_err is unchanged.
  - sync seen in PARITY restarts the frame (word dropped).
- Undefined: no PARITY state, no parity_err port, behaviour exactly as above.

Decomposition:
- Package sipo_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - function clog2 for bit_cnt width ($clog2(WIDTH+1))
  - localparam default width 8
- One natural sub-module, sipo_hold_reg: holding register plus valid/ready/overrun logic. Inputs are load strobe and data; outputs are dout, dout_valid and overrun.
- Shift/FSM stays in the top.

Test Plan:
- Basic, MSB_FIRST=1: mr 2 cycles, then sync+bits 1,0,1,0,0,1,0,1 with ce=1 and dout_ready=0 -> dout=8'hA5, dout_valid=1 on the 8th bit edge, busy drops same edge.
- LSB order: MSB_FIRST=0, same bits -> dout=8'hA5 reversed = 8'hA5 bit-reversed = 8'hA5 ... use bits 1,1,0,0,0,0,0,0 -> dout=8'h03.
- Overrun and simultaneity:
  - Send 8'h3C with ready=0, then 8'hC3 with ready=0 -> dout stays 8'h3C, overrun=1.
  - Repeat with ready=1 on the completion edge -> dout=8'hC3, valid stays 1.
- ce gating: insert ce=0 for 3 cycles mid-frame with sin toggling -> those bits are ignored, result 8'hA5, busy held 1.
- Resync/reset:
  - sync reasserted after 4 bits, followed by 8 bits of 8'h5A -> dout=8'h5A, overrun=0.
  - mr pulsed after 5 bits -> all outputs 0, next sync frame decodes correctly.
- SIPO_PARITY_EN: 8'hA5 + parity 0 -> parity_err=0. 8'hA5 + parity 1 -> parity_err=1. In both cases dout_valid rises one enabled cycle after the last data bit.
